div_sched: RTL and testbench
============================

# div_sched

Round-robin scheduler that shares one combinational `division` unit (32-bit restoring divider: dividend, divisor → quotient, remainder) between NREQ requesters. It accepts one request at a time over a valid/ready handshake and holds the operands stable for a fixed multicycle settle window. It then registers the result and returns it on a shared response bus with a one-hot valid. It sits between the CPU-side requesters (integer unit, address/scale helpers) and the divider datapath.

## Interface
- `NREQ`, default 2: number of requesters, 2..4.
- `WIDTH`, default 32: operand width; must match the `division` instance.
- `SETTLE`, default 2: cycles operands are held on the divider before result capture, ≥1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, NREQ: per-requester request valid.
- `req_ready`, out, NREQ: per-requester accept; at most one bit high.
- `req_dividend`, in, NREQ*WIDTH: packed dividends; requester i at bits [i*WIDTH +: WIDTH].
- `req_divisor`, in, NREQ*WIDTH: packed divisors, same packing.
- `rsp_valid`, out, NREQ: one-hot response valid, addressed to the original requester.
- `rsp_ready`, in, NREQ: per-requester response accept.
- `rsp_quotient`, out, WIDTH: result quotient, shared.
- `rsp_remainder`, out, WIDTH: result remainder, shared.
- `rsp_dz`, out, 1: divide-by-zero flag for the current response.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM has three states: IDLE, SETTLE, RESP.
- **IDLE**
  - The arbiter picks the first requester with `req_valid` high, searching upward from `last_grant+1` modulo NREQ.
  - `req_ready` is high for the granted requester only, in IDLE only. `req_ready` is a combinational function of state and `req_valid`.
  - On handshake: latch operands and owner index, and update `last_grant`.
  - If the divisor is nonzero, go to SETTLE with the counter at SETTLE-1.
  - If the divisor is zero, go directly to RESP with quotient = all ones, remainder = dividend, dz = 1. The divider output is ignored.
- **SETTLE**
  - The latched operands drive the `division` instance; the counter decrements each cycle.
  - When the counter reaches 0: register quotient and remainder, set dz = 0, go to RESP.
- **RESP**
  - `rsp_valid[owner]` is high; the data outputs are held stable.
  - On `rsp_valid[owner] & rsp_ready[owner]`: go to IDLE and drop `rsp_valid` the next cycle.
  - `rsp_ready` bits of non-owners are ignored.
- Requester rules:
  - Once `req_valid` is asserted, the requester holds it and its operands stable until accepted.
  - The scheduler never depends on `req_valid` falling.
- All arithmetic is unsigned, WIDTH bits. No sign handling.

## Timing
- Reset values:
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_quotient`=0, `rsp_remainder`=0, `rsp_dz`=0, `busy`=0.
  - Internal: state=IDLE, `last_grant`=NREQ-1 (requester 0 has first priority).
- Latency, with accept in cycle T:
  - Nonzero divisor: `rsp_valid` rises at T+SETTLE+1.
  - Zero divisor: `rsp_valid` rises at T+1.
- Throughput with `rsp_ready` tied high: one result per SETTLE+2 cycles (nonzero divisor).
  - Accept at T, response T+SETTLE+1, IDLE at T+SETTLE+2.
  - No new request is accepted in the response-handshake cycle.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others keep `req_ready`=0 until a later IDLE cycle.
- Backpressure: while in RESP with `rsp_ready` low, `rsp_*` is held bit-stable indefinitely and all `req_ready` stay 0.
- Reset mid-operation: `rst` high on any edge returns to IDLE with reset values on the next cycle.
  - The in-flight request is dropped without a response; the requester reissues.
  - `rst` wins over every simultaneous handshake.
- Starvation: under continuous requests from all requesters, each requester is served at most once per NREQ grants.

## Structure
- Shared package `div_pkg` holds:
  - the FSM state enum (IDLE/SETTLE/RESP);
  - the default WIDTH;
  - the constant `DZ_QUOTIENT` = all ones.
- Sub-module `rr_arbiter` (NREQ requests, `last_grant` in, one-hot grant out) is combinational and separately testable.
- The existing `division` module is instantiated unchanged, fed from the latched operand registers.

## Test plan
- **Single request:** req0 32/8, SETTLE=2, accept at T → `rsp_valid[0]` at T+3, q=4, r=0, dz=0.
- **Simultaneous requests:** req0 124432/1226 and req1 81/2 in the same cycle after reset.
  - req0 is served first: q=101, r=606.
  - req1 is then served: q=40, r=1, with `rsp_valid[1]` only.
- **Divide by zero:** req1 81/0 accepted at T → `rsp_valid[1]` at T+1, q=32'hFFFFFFFF, r=81, dz=1.
- **Backpressure:**
  - req0 3807872197/25, `rsp_ready` low for 5 cycles → q=152314887 and r=22 held stable, while req1 pending sees `req_ready`=0 throughout.
  - After the response handshake, req1 is granted in the next IDLE cycle.
- **Reset during SETTLE:** `rst` high during SETTLE → next cycle `busy`=0 and `rsp_valid`=0, and no response is ever issued. With both requesters then valid, req0 is granted first.
- **Random:** 200 random operand pairs on random requesters with random `rsp_ready` stalls → every response matches `/` and `%`. A zero divisor matches the dz rule, and the round-robin order matches the reference model.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// div_pkg -- shared FSM state type and constants for the divider scheduler.
// Rev 1.0
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Index width that stays legal (>=1) for tiny counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/division.sv
`default_nettype none
// division -- combinational unsigned restoring divider.
// Rev 1.0
module division #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0] w_rem;

  always_comb begin
    w_rem    = '0;
    quotient = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_rem = {w_rem[WIDTH-1:0], dividend[i]};
      if (w_rem >= {1'b0, divisor}) begin
        w_rem       = w_rem - {1'b0, divisor};
        quotient[i] = 1'b1;
      end
    end
    remainder = w_rem[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick, searching upward from last_grant+1.
// Rev 1.0
module rr_arbiter
  import div_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(last_grant) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = IW'(w_idx);
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_sched.sv
`default_nettype none
// div_sched -- round-robin scheduler sharing one combinational divider between NREQ requesters.
// Rev 1.0
module div_sched
  import div_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WIDTH  = DIV_WIDTH,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dz,
  output logic                  busy
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(SETTLE);
  localparam logic [WIDTH-1:0] DZ_Q = {WIDTH{&DZ_QUOTIENT}};

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_last_grant, r_owner;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_op_a, r_op_b;
  logic [WIDTH-1:0]   r_quot, r_rem;
  logic               r_dz;

  logic [NREQ-1:0]    w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic [WIDTH-1:0]   w_sel_a, w_sel_b;
  logic [WIDTH-1:0]   w_div_q, w_div_r;
  logic               w_accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  division #(.WIDTH(WIDTH)) u_div (
    .dividend  (r_op_a),
    .divisor   (r_op_b),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  assign w_sel_a  = req_dividend[w_grant_idx*WIDTH +: WIDTH];
  assign w_sel_b  = req_divisor[w_grant_idx*WIDTH +: WIDTH];
  assign w_accept = (r_state == ST_IDLE) && (|req_valid);

  // State register plus the operand/result datapath it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IW'(NREQ - 1);
      r_owner      <= '0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_quot       <= '0;
      r_rem        <= '0;
      r_dz         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_cnt        <= CW'(SETTLE - 1);
            if (w_sel_b == '0) begin
              r_quot <= DZ_Q;
              r_rem  <= w_sel_a;
              r_dz   <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_quot <= w_div_q;
            r_rem  <= w_div_r;
            r_dz   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = (w_sel_b == '0) ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready[r_owner]) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (r_state != ST_IDLE);
    if (r_state == ST_IDLE) req_ready = w_grant;
    if (r_state == ST_RESP) rsp_valid[r_owner] = 1'b1;
  end

  assign rsp_quotient  = r_quot;
  assign rsp_remainder = r_rem;
  assign rsp_dz        = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_div_sched.sv
`default_nettype none
// tb_div_sched -- scoreboard bench for div_sched with a round-robin/latency reference model.
// Rev 1.0
module tb_div_sched;

  localparam int NREQ   = 2;
  localparam int W      = 32;
  localparam int SETTLE = 2;

  typedef struct {
    int           owner;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend = '0;
  logic [NREQ*W-1:0] req_divisor = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [W-1:0]      rsp_quotient, rsp_remainder;
  logic              rsp_dz, busy;

  div_sched #(.NREQ(NREQ), .WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_dz        (rsp_dz),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t            pend[NREQ];
  exp_t            sb[$];
  logic            m_busy = 1'b0;
  int              m_cnt  = 0;
  int              m_last = NREQ - 1;
  logic [NREQ-1:0] acc_mask = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] g;
    g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (g == '0 && v[(last + k) % NREQ]) g[(last + k) % NREQ] = 1'b1;
    end
    return g;
  endfunction

  // Requester i raises valid with operands and the result it expects back.
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
    pend[i].owner          = i;
    pend[i].q              = eq;
    pend[i].r              = er;
    pend[i].dz             = edz;
  endtask

  task automatic issue_rand(input int i);
    logic [W-1:0] a, b;
    int           sel;
    a   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0)     b = '0;
    else if (sel < 5) b = W'($urandom_range(1, 300));
    else              b = $urandom;
    if (b == '0) issue(i, a, b, '1, a, 1'b1);
    else         issue(i, a, b, a / b, a % b, 1'b0);
  endtask

  // Runs at the falling edge: compares outputs against the model, then advances it.
  task automatic monitor();
    logic [NREQ-1:0] eg, ev;
    if (rst) return;
    if (m_busy && m_cnt > 0) m_cnt--;
    eg = m_busy ? '0 : rr_pick(req_valid, m_last);
    check("req_ready", 64'(req_ready), 64'(eg));
    check("busy", 64'(busy), 64'(m_busy));
    ev = '0;
    if (m_busy && m_cnt == 0 && sb.size() > 0) ev[sb[0].owner] = 1'b1;
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev != '0) begin
      check("rsp_quotient", 64'(rsp_quotient), 64'(sb[0].q));
      check("rsp_remainder", 64'(rsp_remainder), 64'(sb[0].r));
      check("rsp_dz", 64'(rsp_dz), 64'(sb[0].dz));
      if (rsp_ready[sb[0].owner]) begin
        void'(sb.pop_front());
        m_busy = 1'b0;
      end
    end
    if (eg != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (eg[i]) begin
          sb.push_back(pend[i]);
          m_last = i;
          m_cnt  = pend[i].dz ? 1 : SETTLE + 1;
        end
      end
      m_busy   = 1'b1;
      acc_mask = eg;
    end
  endtask

  task automatic tick();
    acc_mask = '0;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    sb.delete();
    m_busy    = 1'b0;
    m_cnt     = 0;
    m_last    = NREQ - 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_quotient", 64'(rsp_quotient), 64'(0));
    check("rst_remainder", 64'(rsp_remainder), 64'(0));
    check("rst_dz", 64'(rsp_dz), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_busy || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(n >= budget), 64'(0));
  endtask

  initial begin
    int issued, cycles;
    @(posedge clk);
    #1;
    do_reset();

    // Single request: 32/8
    rsp_ready = '1;
    issue(0, 32, 8, 4, 0, 1'b0);
    wait_done("single_drain", 20);

    // Simultaneous requests straight after reset
    do_reset();
    rsp_ready = '1;
    issue(0, 124432, 1226, 101, 606, 1'b0);
    issue(1, 81, 2, 40, 1, 1'b0);
    wait_done("simul_drain", 40);

    // Divide by zero
    issue(1, 81, 0, 32'hFFFF_FFFF, 81, 1'b1);
    wait_done("dz_drain", 20);

    // Backpressure with a second requester waiting
    rsp_ready = '0;
    issue(0, 32'd3807872197, 25, 152314887, 22, 1'b0);
    tick();
    issue(1, 5, 3, 1, 2, 1'b0);
    repeat (SETTLE + 1 + 5) tick();
    rsp_ready = '1;
    wait_done("bp_drain", 40);

    // Reset while in SETTLE drops the in-flight request
    issue(0, 100, 7, 14, 2, 1'b0);
    tick();
    tick();
    check("settle_busy", 64'(busy), 64'(1));
    do_reset();
    issue(0, 1000, 10, 100, 0, 1'b0);
    issue(1, 9, 4, 2, 1, 1'b0);
    wait_done("post_rst_drain", 40);

    // Random traffic with response stalls
    issued = 0;
    cycles = 0;
    while ((issued < 200 || sb.size() != 0 || m_busy || req_valid != '0) && cycles < 20000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && issued < 200 && $urandom_range(0, 2) == 0) begin
          issue_rand(i);
          issued++;
        end
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
      cycles++;
    end
    check("random_drain", 64'(cycles >= 20000), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
